// File: rtl/coherence_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and sizing for the coherence bus arbiter and the bus-controller
// interface.
//   CPUS / CPU_ID_LENGTH : default requester count and core-id width
//   arb_state_t          : arbiter FSM states
//   arb_req_t            : transaction class handed to the bus controller
//   classify_req()       : maps writeback/exclusive flags to arb_req_t
// -----------------------------------------------------------------------------
package bus_arb_pkg;

  localparam int CPUS          = 2;
  localparam int CPU_ID_LENGTH = $clog2(CPUS);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OFFER   = 2'd1,
    ARB_OWN     = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    ARB_R  = 2'd0,
    ARB_RX = 2'd1,
    ARB_WB = 2'd2
  } arb_req_t;

  // An eviction outranks the exclusivity flag: a writeback never needs
  // ownership, whatever ccwrite says.
  function automatic arb_req_t classify_req(input logic wb, input logic x);
    if (wb) return ARB_WB;
    if (x)  return ARB_RX;
    return ARB_R;
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// coherence_bus_arbiter_if
// Request/grant bundle between the L1 requesters, the arbiter and the bus
// controller.
//   req, req_wb, req_x : per-core request level, writeback flag, exclusive flag
//   gnt_ack, txn_done  : controller accepted the grant / finished the transaction
//   grant_valid, grant_id, grant_onehot, grant_type : current grant
//   busy               : grant owned by the controller
//   timeout            : watchdog pulse
// Modports: master = arbiter side, slave = requester/controller side.
// -----------------------------------------------------------------------------
interface coherence_bus_arbiter_if #(
  parameter int CPUS          = bus_arb_pkg::CPUS,
  parameter int CPU_ID_LENGTH = $clog2(CPUS)
);
  import bus_arb_pkg::*;

  logic [CPUS-1:0]          req;
  logic [CPUS-1:0]          req_wb;
  logic [CPUS-1:0]          req_x;
  logic                     gnt_ack;
  logic                     txn_done;
  logic                     grant_valid;
  logic [CPU_ID_LENGTH-1:0] grant_id;
  logic [CPUS-1:0]          grant_onehot;
  arb_req_t                 grant_type;
  logic                     busy;
  logic                     timeout;

  modport master (
    input  req, req_wb, req_x, gnt_ack, txn_done,
    output grant_valid, grant_id, grant_onehot, grant_type, busy, timeout
  );

  modport slave (
    output req, req_wb, req_x, gnt_ack, txn_done,
    input  grant_valid, grant_id, grant_onehot, grant_type, busy, timeout
  );

endinterface

// File: rtl/coherence_bus_arbiter_rr_priority_sel.sv
// -----------------------------------------------------------------------------
// rr_priority_sel
// Combinational rotating-priority encoder: returns the first set request bit
// scanning rr_ptr, rr_ptr+1, ... wrapping at CPUS-1 -> 0. CPUS need not be a
// power of two.
//   req     : request vector
//   rr_ptr  : highest-priority index (must be < CPUS)
//   any_req : at least one request set
//   sel_id  : selected index (0 when any_req=0)
// -----------------------------------------------------------------------------
module rr_priority_sel #(
  parameter int CPUS          = 2,
  parameter int CPU_ID_LENGTH = $clog2(CPUS)
) (
  input  logic [CPUS-1:0]          req,
  input  logic [CPU_ID_LENGTH-1:0] rr_ptr,
  output logic                     any_req,
  output logic [CPU_ID_LENGTH-1:0] sel_id
);

  logic found;

  // Two linear passes instead of a modular index: the first covers
  // rr_ptr..CPUS-1, the second picks up the wrapped part 0..rr_ptr-1.
  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    any_req = |req;
    sel_id  = '0;
    found   = 1'b0;
    for (int j = 0; j < CPUS; j++) begin
      if (!found && req[j] && (j >= int'(rr_ptr))) begin
        found  = 1'b1;
        sel_id = CPU_ID_LENGTH'(j);
      end
    end
    for (int j = 0; j < CPUS; j++) begin
      if (!found && req[j]) begin
        found  = 1'b1;
        sel_id = CPU_ID_LENGTH'(j);
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// -----------------------------------------------------------------------------
// coherence_bus_arbiter
// Round-robin arbiter sharing one coherence bus controller between CPUS L1
// requesters. Offers a grant, holds it while the controller owns the bus,
// classifies the request and releases on txn_done or watchdog expiry.
//   clk  : system clock
//   RST  : asynchronous, active-high reset
//   bus  : coherence_bus_arbiter_if.master (requests in, registered grant out)
// Parameters: CPUS (>=2), CPU_ID_LENGTH, TIMEOUT_CYCLES (0 disables watchdog).
// -----------------------------------------------------------------------------
module coherence_bus_arbiter #(
  parameter int CPUS           = bus_arb_pkg::CPUS,
  parameter int CPU_ID_LENGTH  = $clog2(CPUS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           RST,
  coherence_bus_arbiter_if.master        bus
);
  import bus_arb_pkg::*;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  arb_state_t               state;
  logic [CPU_ID_LENGTH-1:0] rr_ptr;
  logic [WD_W-1:0]          wd_cnt;

  logic                     grant_valid_q;
  logic [CPU_ID_LENGTH-1:0] grant_id_q;
  logic [CPUS-1:0]          grant_onehot_q;
  arb_req_t                 grant_type_q;
  logic                     busy_q;
  logic                     timeout_q;

  logic                     any_req;
  logic [CPU_ID_LENGTH-1:0] sel_id;
  logic [CPUS-1:0]          sel_onehot;
  logic                     req_held;
  logic                     wd_hit;

  rr_priority_sel #(
    .CPUS          (CPUS),
    .CPU_ID_LENGTH (CPU_ID_LENGTH)
  ) u_sel (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .sel_id  (sel_id)
  );

  assign sel_onehot = CPUS'(1) << sel_id;
  // The registered one-hot doubles as a mask for "is the granted core still
  // asking", avoiding a variable index into req.
  assign req_held   = |(bus.req & grant_onehot_q);
  assign wd_hit     = WD_EN && (wd_cnt == WD_LIMIT);

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state          <= ARB_IDLE;
      rr_ptr         <= '0;
      wd_cnt         <= '0;
      grant_valid_q  <= 1'b0;
      grant_id_q     <= '0;
      grant_onehot_q <= '0;
      grant_type_q   <= ARB_R;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            state          <= ARB_OFFER;
            grant_valid_q  <= 1'b1;
            grant_id_q     <= sel_id;
            grant_onehot_q <= sel_onehot;
            grant_type_q   <= classify_req(|(bus.req_wb & sel_onehot),
                                           |(bus.req_x  & sel_onehot));
            wd_cnt         <= '0;
          end
        end

        ARB_OFFER: begin
          if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          if (bus.gnt_ack) begin
            // Ack outranks a same-cycle withdrawal: the controller has
            // already committed to this core.
            state  <= ARB_OWN;
            busy_q <= 1'b1;
          end else if (wd_hit) begin
            state          <= ARB_RELEASE;
            timeout_q      <= 1'b1;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
          end else if (!req_held) begin
            // Withdrawn before ack: back off without moving rr_ptr so the
            // same priority order applies to the next decision.
            state          <= ARB_IDLE;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
          end
        end

        ARB_OWN: begin
          if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          if (bus.txn_done || wd_hit) begin
            // Completion on the limit cycle is a normal release.
            state          <= ARB_RELEASE;
            timeout_q      <= !bus.txn_done;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
            busy_q         <= 1'b0;
          end
        end

        ARB_RELEASE: begin
          // One-cycle bubble; the pointer moves past the core just served
          // (or just timed out), which bounds every waiter to CPUS-1 grants.
          rr_ptr <= (grant_id_q == CPU_ID_LENGTH'(CPUS - 1)) ? '0
                                                              : grant_id_q + 1'b1;
          state  <= ARB_IDLE;
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_onehot = grant_onehot_q;
  assign bus.grant_type   = grant_type_q;
  assign bus.busy         = busy_q;
  assign bus.timeout      = timeout_q;

endmodule
